// File: rtl/time_keeper_if.sv
// Keypad, tick and alarm bundle between the time keeper and its users.
// master drives keys/ticks; slave is the time keeper itself.
interface time_keeper_if;
  logic       one_minute;
  logic       load_time;
  logic       load_alarm;
  logic [1:0] key_hr_tens;
  logic [3:0] key_hr_ones;
  logic [2:0] key_min_tens;
  logic [3:0] key_min_ones;
  logic       alarm_on;
  logic       stop_alarm;
  logic       snooze;
  logic [1:0] cur_hr_tens;
  logic [3:0] cur_hr_ones;
  logic [2:0] cur_min_tens;
  logic [3:0] cur_min_ones;
  logic [1:0] alm_hr_tens;
  logic [3:0] alm_hr_ones;
  logic [2:0] alm_min_tens;
  logic [3:0] alm_min_ones;
  logic       alarm_ring;
  logic       reset_count;
  logic       load_err;

  modport master (
    output one_minute, load_time, load_alarm,
    output key_hr_tens, key_hr_ones,
    output key_min_tens, key_min_ones,
    output alarm_on, stop_alarm, snooze,
    input  cur_hr_tens, cur_hr_ones,
    input  cur_min_tens, cur_min_ones,
    input  alm_hr_tens, alm_hr_ones,
    input  alm_min_tens, alm_min_ones,
    input  alarm_ring, reset_count, load_err
  );

  modport slave (
    input  one_minute, load_time, load_alarm,
    input  key_hr_tens, key_hr_ones,
    input  key_min_tens, key_min_ones,
    input  alarm_on, stop_alarm, snooze,
    output cur_hr_tens, cur_hr_ones,
    output cur_min_tens, cur_min_ones,
    output alm_hr_tens, alm_hr_ones,
    output alm_min_tens, alm_min_ones,
    output alarm_ring, reset_count, load_err
  );
endinterface

// File: rtl/time_keeper.sv
// 24h BCD clock + alarm fed by one_minute ticks.
// Define ALARM_SNOOZE_EN to build the snooze counter.
module time_keeper #(
  parameter int RING_MINUTES   = 1,
  parameter int SNOOZE_MINUTES = 5
) (
  input logic          clk,
  input logic          reset,
  time_keeper_if.slave bus
);

  typedef struct packed {
    logic [1:0] ht;
    logic [3:0] ho;
    logic [2:0] mt;
    logic [3:0] mo;
  } hm_t;

  localparam logic [3:0] RING_N = 4'(RING_MINUTES);

  hm_t        cur_q, cur_d;
  hm_t        alm_q, alm_d;
  hm_t        keys;
  logic       ring_q, ring_d;
  logic [3:0] rcnt_q, rcnt_d;
  logic       tchg_q, tchg_d;
  logic       rc_q, rc_d;
  logic       err_q, err_d;
  logic       key_ok;
  logic       lt_ok;
  logic       la_ok;
  logic       tick;

  function automatic hm_t inc(hm_t t);
    hm_t r;
    r = t;
    if (t.mo != 4'd9) begin
      r.mo = t.mo + 4'd1;
    end else begin
      r.mo = '0;
      if (t.mt != 3'd5) begin
        r.mt = t.mt + 3'd1;
      end else begin
        r.mt = '0;
        if (t.ht == 2'd2 && t.ho == 4'd3) begin
          r.ht = '0;
          r.ho = '0;
        end else if (t.ho == 4'd9) begin
          r.ho = '0;
          r.ht = t.ht + 2'd1;
        end else begin
          r.ho = t.ho + 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign keys = '{bus.key_hr_tens, bus.key_hr_ones,
                  bus.key_min_tens, bus.key_min_ones};

  assign key_ok = (keys.ht <= 2'd2) && (keys.ho <= 4'd9)
               && !(keys.ht == 2'd2 && keys.ho > 4'd3)
               && (keys.mt <= 3'd5) && (keys.mo <= 4'd9);

  assign lt_ok = bus.load_time && key_ok;
  assign la_ok = bus.load_alarm && key_ok;
  assign tick  = bus.one_minute;

`ifdef ALARM_SNOOZE_EN
  localparam logic [3:0] SNZ_N = 4'(SNOOZE_MINUTES);
  logic [3:0] snz_q, snz_d;
`else
  logic [4:0] unused_snz;
  assign unused_snz = {bus.snooze, 4'(SNOOZE_MINUTES)};
`endif

  always_comb begin
    cur_d  = cur_q;
    alm_d  = alm_q;
    ring_d = ring_q;
    rcnt_d = rcnt_q;
    rc_d   = lt_ok;
    err_d  = (bus.load_time || bus.load_alarm) && !key_ok;
    tchg_d = lt_ok || tick;
`ifdef ALARM_SNOOZE_EN
    snz_d  = snz_q;
`endif
    // An accepted time load swallows a coincident tick
    if (lt_ok)     cur_d = keys;
    else if (tick) cur_d = inc(cur_q);
    if (la_ok)     alm_d = keys;

    if (bus.stop_alarm || !bus.alarm_on) begin
      ring_d = 1'b0;
      rcnt_d = '0;
`ifdef ALARM_SNOOZE_EN
      snz_d  = '0;
`endif
    end else begin
      if (ring_q && tick) begin
        if (rcnt_q <= 4'd1) begin
          ring_d = 1'b0;
          rcnt_d = '0;
        end else begin
          rcnt_d = rcnt_q - 4'd1;
        end
      end
`ifdef ALARM_SNOOZE_EN
      if (lt_ok || la_ok) begin
        snz_d = '0;
      end else if (ring_q && bus.snooze) begin
        ring_d = 1'b0;
        rcnt_d = '0;
        snz_d  = SNZ_N;
      end else if (snz_q != '0 && tick) begin
        if (snz_q == 4'd1) begin
          snz_d  = '0;
          ring_d = 1'b1;
          rcnt_d = RING_N;
        end else begin
          snz_d = snz_q - 4'd1;
        end
      end
`endif
      // Only a change of time arms the match, not an alarm edit
      if (tchg_q && cur_q == alm_q) begin
        ring_d = 1'b1;
        rcnt_d = RING_N;
`ifdef ALARM_SNOOZE_EN
        snz_d  = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_q  <= '0;
      alm_q  <= '0;
      ring_q <= 1'b0;
      rcnt_q <= '0;
      tchg_q <= 1'b0;
      rc_q   <= 1'b0;
      err_q  <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_q  <= '0;
`endif
    end else begin
      cur_q  <= cur_d;
      alm_q  <= alm_d;
      ring_q <= ring_d;
      rcnt_q <= rcnt_d;
      tchg_q <= tchg_d;
      rc_q   <= rc_d;
      err_q  <= err_d;
`ifdef ALARM_SNOOZE_EN
      snz_q  <= snz_d;
`endif
    end
  end

  assign bus.cur_hr_tens  = cur_q.ht;
  assign bus.cur_hr_ones  = cur_q.ho;
  assign bus.cur_min_tens = cur_q.mt;
  assign bus.cur_min_ones = cur_q.mo;
  assign bus.alm_hr_tens  = alm_q.ht;
  assign bus.alm_hr_ones  = alm_q.ho;
  assign bus.alm_min_tens = alm_q.mt;
  assign bus.alm_min_ones = alm_q.mo;
  assign bus.alarm_ring   = ring_q;
  assign bus.reset_count  = rc_q;
  assign bus.load_err     = err_q;

endmodule

// File: doc/time_keeper.md
Name: time_keeper

Overview:
- Consumer end of the minute-tick interface: counts one_minute pulses from the tick generator and holds time of day as 24-hour BCD (HH:MM).
- Also stores the alarm time and drives alarm_ring.
- Loads new time/alarm from keypad digit buses.
- Sends reset_count back to the tick generator so the minute phase restarts on every accepted time load.

Parameters:
- RING_MINUTES, 1, number of one_minute ticks alarm_ring stays high before auto-clear (1..15).
- SNOOZE_MINUTES, 5, ticks between snooze and re-ring (only with SNOOZE_EN; 1..15).

Ports:
- clk  input  1  system clock (256 Hz domain, same as tick generator)
- reset  input  1  asynchronous, active-high
- one_minute  input  1  single-cycle tick from the generator
- load_time  input  1  pulse: load key_* digits into the time registers
- load_alarm  input  1  pulse: load key_* digits into the alarm registers
- key_hr_tens  input  2  BCD hour tens
- key_hr_ones  input  4  BCD hour ones
- key_min_tens  input  3  BCD minute tens
- key_min_ones  input  4  BCD minute ones
- alarm_on  input  1  level: alarm enabled
- stop_alarm  input  1  pulse: silence ringing alarm
- snooze  input  1  pulse: snooze (SNOOZE_EN only)
- cur_hr_tens, cur_hr_ones, cur_min_tens, cur_min_ones  output  2/4/3/4  current time, BCD
- alm_hr_tens, alm_hr_ones, alm_min_tens, alm_min_ones  output  2/4/3/4  stored alarm time, BCD
- alarm_ring  output  1  alarm sounding
- reset_count  output  1  pulse to tick generator
- load_err  output  1  pulse: rejected load

Behaviour:
- Reset (async): all time and alarm digits 0 (00:00); alarm_ring, reset_count and load_err 0; ring and snooze counters 0.
- All outputs are registered. Every effect appears on the clk edge after the sampled input.
- Validity of a key set: hr_tens ≤ 2; hr_ones ≤ 9, and ≤ 3 when hr_tens = 2; min_tens ≤ 5; min_ones ≤ 9.
- load_time with a valid key set:
  - Time registers take the keys.
  - reset_count = 1 for exactly one cycle (the same edge).
  - A one_minute in the same cycle is discarded.
- load_alarm with a valid key set: alarm registers take the keys. The time registers are unaffected; a coincident tick still increments time.
- load_time and load_alarm together: both registers load; a single reset_count pulse.
- Invalid key set: the targeted registers are unchanged, load_err = 1 for one cycle, no reset_count.
- Tick increment (one_minute = 1, no accepted load_time):
  - min_ones +1. At 9 it wraps to 0 and carries into min_tens.
  - min_tens wraps at 5→0 and carries to hours.
  - Hours increment BCD; 23→00, so 23:59 → 00:00.
  - One increment per tick cycle. A tick held high N cycles gives N increments.
- Alarm match:
  - Match is evaluated on the registered time.
  - Ring triggers in the cycle after time newly becomes equal to the alarm time, when alarm_on = 1. "Newly equal" covers both a tick and a load_time.
  - Editing the alarm to equal the current time does not trigger.
- Ringing:
  - alarm_ring = 1, and the ring counter loads RING_MINUTES.
  - Each subsequent tick decrements the counter. Ring clears when the counter hits 0.
  - Ring also clears the cycle after stop_alarm = 1 or alarm_on = 0.
  - Priority: stop_alarm/alarm_on low over a new trigger in the same cycle.
- Reset mid-ring or mid-load: immediate return to reset values.

Optional Feature:
- Macro: ALARM_SNOOZE_EN.
- Defined:
  - snooze = 1 while ringing clears alarm_ring and arms the snooze counter with SNOOZE_MINUTES.
  - Each tick decrements the snooze counter. At 0, ring re-triggers with a fresh RING_MINUTES.
  - stop_alarm, alarm_on = 0, or an accepted load_time/load_alarm cancel a pending snooze.
  - snooze while not ringing is ignored.
- Not defined:
  - snooze input is ignored and no snooze counter is synthesized.
  - Behaviour is otherwise identical.

Test Plan:
- Reset, then 61 ticks → time 01:01; 1440 ticks from 00:00 → 00:00. Check 09:59→10:00 and 19:59→20:00.
- Load 23:59 → reset_count high exactly one cycle; next tick → 00:00.
- load_time coincident with a tick → loaded value shown, no increment.
- Load 24:00 or 12:60 → load_err one cycle; time unchanged; no reset_count.
- Alarm 07:30, alarm_on = 1, time 07:29, one tick → alarm_ring = 1 next cycle. With RING_MINUTES = 1, next tick → ring cleared.
- Repeat the ring, then stop_alarm → ring 0 next cycle.
- With ALARM_SNOOZE_EN, SNOOZE_MINUTES = 5: snooze at 07:30 → ring 0; re-ring after the 5th tick (07:35). Repeat with alarm_on dropped during snooze → no re-ring.
